// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and digit helper for the display scan path
package display_pkg;

    localparam int DIGIT_W    = 4;
    // Widest value the digit helper accepts; callers zero-extend into it.
    localparam int MAX_DIGITS = 16;
    localparam int MAX_W      = DIGIT_W * MAX_DIGITS;

    typedef enum logic {
        SCAN_ON    = 1'b0,
        SCAN_BLANK = 1'b1
    } scan_state_t;

    // Digit k of a packed value, digit 0 in the least significant nibble.
    function automatic logic [DIGIT_W-1:0] get_digit(input logic [MAX_W-1:0] value, input int k);
        return value[k*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/display_refresh_timer.sv
// rtl/display_refresh_timer.sv - per-slot counter producing blank_start and slot_end strobes
module display_refresh_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    output logic blank_start,
    output logic slot_end
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_ON  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running slot counter, 0..REFRESH_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign slot_end    = (cnt == LAST_CNT);
    // With no blank phase the ON phase runs to slot_end, so never request blanking.
    assign blank_start = (BLANK_CYCLES != 0) && (cnt == LAST_ON);

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - multiplexed digit scanner with blanking gap and frame-aligned value updates (option: LEADING_ZERO_BLANK_EN)
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     value_in,
    output logic [DIGIT_W-1:0]          digit_code,
    output logic                        seg_en,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int VAL_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  blank_start;
    logic                  slot_end;
    scan_state_t           state;
    scan_state_t           state_d;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      shadow;
    logic [VAL_W-1:0]      shadow_d;
    logic [VAL_W-1:0]      pending;
    logic                  pend_flag;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_d;
    logic                  seg_en_d;
    logic [DIGIT_W-1:0]    code_d;

    display_refresh_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .blank_start (blank_start),
        .slot_end    (slot_end)
    );

    // Scan state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SCAN_ON;
        end else begin
            state <= state_d;
        end
    end

    // Next scan state: ON until blank_start, BLANK until slot_end
    always_comb begin
        state_d = state;
        case (state)
            SCAN_ON:    if (blank_start) state_d = SCAN_BLANK;
            SCAN_BLANK: if (slot_end)    state_d = SCAN_ON;
            default:    state_d = SCAN_ON;
        endcase
    end

    // Digit index steps once per slot and wraps after the last digit
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (slot_end) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    // Shadow only changes in the frame_done cycle; a load in that very cycle wins over pending
    always_comb begin
        shadow_d = shadow;
        if (frame_done) begin
            if (load) begin
                shadow_d = value_in;
            end else if (pend_flag) begin
                shadow_d = pending;
            end
        end
    end

    // Pending capture and shadow commit
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else begin
            shadow <= shadow_d;
            if (load) begin
                pending <= value_in;
            end
            if (frame_done) begin
                pend_flag <= 1'b0;
            end else if (load) begin
                pend_flag <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Light the slot unless it and every more significant digit are zero; digit 0 always lit
    always_comb begin
        lit = (idx == '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && get_digit(MAX_W'(shadow_d), k) != '0) begin
                lit = 1'b1;
            end
        end
    end
`else
    assign lit = 1'b1;
`endif

    // Next output values; BLANK darkens everything and holds the last code
    always_comb begin
        an_d     = '1;
        seg_en_d = 1'b0;
        code_d   = digit_code;
        if (state == SCAN_ON) begin
            an_d[idx] = 1'b0;
            seg_en_d  = lit;
            code_d    = get_digit(MAX_W'(shadow_d), int'(idx));
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            seg_en     <= 1'b0;
            digit_code <= '0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            seg_en     <= seg_en_d;
            digit_code <= code_d;
            frame_done <= slot_end && (idx == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - self-checking bench for display_scan_mux
module tb_display_scan_mux;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  digit_code;
    logic        seg_en;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    display_scan_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value_in   (value_in),
        .digit_code (digit_code),
        .seg_en     (seg_en),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit_chk(input string nm, input logic [3:0] an_e, input logic seg_e, input logic [3:0] code_e);
        chk({nm, "_an"}, an, an_e);
        chk({nm, "_seg_en"}, seg_en, seg_e);
        chk({nm, "_code"}, digit_code, code_e);
    endtask

    task automatic wait_fd();
        int n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame_done timeout actual %b required 1", frame_done);
        end
    endtask

    // Model: t counts output cycles since reset release; everything derives from it
    int          t = -1;
    bit          valid = 1'b0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_pend = '0;
    bit          m_flag = 1'b0;
    int          m_pos;
    int          m_dig;
    bit          m_on;
    logic [3:0]  m_an;

    function automatic bit m_lit(input logic [15:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        int nd = 1;
        for (int k = 0; k < ND; k++) begin
            if (v[4*k +: 4] != 4'h0) nd = k + 1;
        end
        return d < nd;
`else
        return 1'b1;
`endif
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            if (t < 0) begin
                chk("m_dark_an", an, 4'hF);
                chk("m_dark_seg_en", seg_en, 1'b0);
                chk("m_dark_code", digit_code, 4'h0);
                chk("m_dark_frame_done", frame_done, 1'b0);
            end else begin
                m_pos = t % RD;
                m_dig = (t / RD) % ND;
                m_on  = (m_pos < RD - BC);
                m_an  = m_on ? ~(4'b0001 << m_dig) : 4'hF;
                chk("m_an", an, m_an);
                chk("m_seg_en", seg_en, m_on && m_lit(m_shadow, m_dig));
                chk("m_code", digit_code, m_shadow[4*m_dig +: 4]);
                chk("m_frame_done", frame_done, (t % FRAME) == FRAME - 1);
            end
        end
        if (rst) begin
            valid    = 1'b1;
            t        = -1;
            m_shadow = '0;
            m_pend   = '0;
            m_flag   = 1'b0;
        end else if (valid) begin
            if (t >= 0 && (t % FRAME) == FRAME - 1) begin
                if (load) m_shadow = value_in;
                else if (m_flag) m_shadow = m_pend;
                m_flag = 1'b0;
            end else if (load) begin
                m_flag = 1'b1;
            end
            if (load) m_pend = value_in;
            t++;
        end
    end

    task automatic pulse_load(input logic [15:0] v);
        @(posedge clk); #1;
        load = 1'b1;
        value_in = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] codes [4];
        logic       segs [4];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        lit_chk("reset", 4'hF, 1'b0, 4'h0);
        chk("reset_frame_done", frame_done, 1'b0);
        @(negedge clk);
        lit_chk("first_on", 4'b1110, 1'b1, 4'h0);

        // 1: 1234 across a whole frame
        pulse_load(16'h1234);
        wait_fd();
        codes = '{4'h4, 4'h3, 4'h2, 4'h1};
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c % RD < RD - BC)
                lit_chk("t1_on", ~(4'b0001 << (c / RD)), 1'b1, codes[c / RD]);
            else
                lit_chk("t1_blank", 4'hF, 1'b0, codes[c / RD]);
            if (c == FRAME - 2) chk("t1_fd_low", frame_done, 1'b0);
            if (c == FRAME - 1) chk("t1_fd_period", frame_done, 1'b1);
        end

        // 2: load during digit 2 takes effect next frame
        repeat (18) @(negedge clk);
        pulse_load(16'h5678);
        wait_fd();
        @(negedge clk);
        lit_chk("t2_next_frame", 4'b1110, 1'b1, 4'h8);

        // 3: last of two loads wins
        pulse_load(16'hAAAA);
        pulse_load(16'h0BCD);
        wait_fd();
        codes = '{4'hD, 4'hC, 4'hB, 4'h0};
        segs  = '{1'b1, 1'b1, 1'b1, !LZB};
        for (int d = 0; d < ND; d++) begin
            @(negedge clk);
            lit_chk("t3_digit", ~(4'b0001 << d), segs[d], codes[d]);
            repeat (RD - 1) @(negedge clk);
        end

        // 4: load in the frame_done cycle shows on the very next digit-0 slot
        repeat (FRAME - 1) @(negedge clk);
        @(posedge clk); #1;
        chk("t4_fd_coincident", frame_done, 1'b1);
        load = 1'b1;
        value_in = 16'h9ABC;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        lit_chk("t4_direct", 4'b1110, 1'b1, 4'hC);

        // 6: reset mid-ON of digit 2
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        lit_chk("t6_dark", 4'hF, 1'b0, 4'h0);
        chk("t6_frame_done", frame_done, 1'b0);
        @(negedge clk);
        lit_chk("t6_cleared", 4'b1110, 1'b1, 4'h0);

`ifdef LEADING_ZERO_BLANK_EN
        // 5: leading zero suppression
        pulse_load(16'h0042);
        wait_fd();
        codes = '{4'h2, 4'h4, 4'h0, 4'h0};
        segs  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int d = 0; d < ND; d++) begin
            @(negedge clk);
            lit_chk("t5_0042", ~(4'b0001 << d), segs[d], codes[d]);
            repeat (RD - 1) @(negedge clk);
        end
        pulse_load(16'h0000);
        wait_fd();
        segs = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int d = 0; d < ND; d++) begin
            @(negedge clk);
            lit_chk("t5_zero", ~(4'b0001 << d), segs[d], 4'h0);
            repeat (RD - 1) @(negedge clk);
        end
`endif

        repeat (FRAME) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
